// File: rtl/mcu_pkg.sv
// Shared MCU definitions: opcode values used by the control unit and the
// sequencer state encoding.
package mcu_pkg;

  localparam logic [3:0] ADD   = 4'b0000;
  localparam logic [3:0] SUB   = 4'b0001;
  localparam logic [3:0] STORE = 4'b0010;
  localparam logic [3:0] LOAD  = 4'b0011;
  localparam logic [3:0] MOV   = 4'b0100;
  localparam logic [3:0] MOVI  = 4'b0101;
  localparam logic [3:0] JMP   = 4'b0111;
  localparam logic [3:0] NOP   = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-ack wait counter for the sequencer timeout (built only with SEQ_TIMEOUT_EN).
// o_last flags that one more unacknowledged cycle reaches the LIMIT.
module seq_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_cnt <= 8'd0;
    else if (i_clear)
      r_cnt <= 8'd0;
    else if (i_inc)
      r_cnt <= r_cnt + 8'd1;
  end

  assign o_last = (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer owning the shared memory port handshake.
// Define SEQ_TIMEOUT_EN to add the mem_ack timeout and the sticky FAULT state.
module instr_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [3:0] i_opcode,
  input  logic       i_mem_ack,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_load_ir,
  output logic       o_exec_en,
  output logic       o_wb_en,
  output logic       o_pc_en,
  output logic       o_instr_done,
  output logic       o_busy,
  output logic       o_fault
);

  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be in 1..255");
  end

  seq_state_t r_state;
  seq_state_t w_next;
  logic [3:0] r_op_q;
  logic       w_timeout;
  logic       w_boundary_fetch;

  assign w_boundary_fetch = i_run;

`ifdef SEQ_TIMEOUT_EN
  logic w_clear;
  logic w_stall;
  logic w_last;

  // Counter restarts whenever a new memory phase is entered.
  assign w_clear   = (w_next != r_state) && ((w_next == ST_FETCH) || (w_next == ST_MEM));
  assign w_stall   = o_mem_req & ~i_mem_ack;
  assign w_timeout = w_stall & w_last;

  seq_wait_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_inc   (w_stall),
    .o_last  (w_last)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_op_q <= 4'd0;
    else if (r_state == ST_DECODE)
      r_op_q <= i_opcode;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_run) w_next = ST_FETCH;
      ST_FETCH: begin
        if (i_mem_ack)      w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_op(r_op_q)) w_next = ST_MEM;
        else                   w_next = w_boundary_fetch ? ST_FETCH : ST_IDLE;
      end
      ST_MEM: begin
        if (i_mem_ack)      w_next = w_boundary_fetch ? ST_FETCH : ST_IDLE;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_FAULT:  w_next = ST_FAULT;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs follow the state register; reset forces them low immediately.
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_load_ir    = 1'b0;
    o_exec_en    = 1'b0;
    o_wb_en      = 1'b0;
    o_pc_en      = 1'b0;
    o_instr_done = 1'b0;
    o_busy       = 1'b0;
    o_fault      = 1'b0;
    if (!i_reset) begin
      o_busy = (r_state != ST_IDLE);
      case (r_state)
        ST_FETCH: begin
          o_mem_req = 1'b1;
          o_load_ir = i_mem_ack;
        end
        ST_EXEC: begin
          o_exec_en    = 1'b1;
          o_instr_done = ~is_mem_op(r_op_q);
          o_pc_en      = ~is_mem_op(r_op_q);
        end
        ST_MEM: begin
          o_mem_req    = 1'b1;
          o_mem_we     = (r_op_q == STORE);
          o_wb_en      = i_mem_ack & (r_op_q == LOAD);
          o_instr_done = i_mem_ack;
          o_pc_en      = i_mem_ack;
        end
`ifdef SEQ_TIMEOUT_EN
        ST_FAULT: o_fault = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a per-instruction cycle-schedule model
// predicts every output each cycle. Timeout section is active with SEQ_TIMEOUT_EN.
module tb_instr_sequencer;

  localparam int unsigned TO = 3;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [3:0] OP_UNDEF = 4'b0110;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_run;
  logic [3:0] i_opcode;
  logic       i_mem_ack;
  logic       o_mem_req, o_mem_we, o_load_ir, o_exec_en, o_wb_en;
  logic       o_pc_en, o_instr_done, o_busy, o_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_sequencer #(
    .ACK_TIMEOUT (TO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
    .i_opcode     (i_opcode),
    .i_mem_ack    (i_mem_ack),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_load_ir    (o_load_ir),
    .o_exec_en    (o_exec_en),
    .o_wb_en      (o_wb_en),
    .o_pc_en      (o_pc_en),
    .o_instr_done (o_instr_done),
    .o_busy       (o_busy),
    .o_fault      (o_fault)
  );

  function automatic logic [8:0] outs();
    return {o_mem_req, o_mem_we, o_load_ir, o_exec_en, o_wb_en,
            o_pc_en, o_instr_done, o_busy, o_fault};
  endfunction

  // Expected output vector: req, we, load_ir, exec_en, wb_en, pc_en, done, busy, fault
  function automatic logic [8:0] V(input bit req, we, ir, ex, wb, pc, dn, bz, ft);
    return {req, we, ir, ex, wb, pc, dn, bz, ft};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %09b expected %09b (req we ir ex wb pc done busy fault) at %0t",
               tag, obs[8:0], exp[8:0], $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic run, input logic ack, input logic [3:0] op,
                      input logic [8:0] e, input string tag);
    @(negedge clk);
    i_run     = run;
    i_mem_ack = ack;
    i_opcode  = op;
    #1 check_eq(tag, 32'(outs()), 32'(e));
  endtask

  // One instruction starting in FETCH; run_end is the run level at the boundary.
  task automatic do_instr(input logic [3:0] op, input int fw, input int mw, input logic run_end);
    bit is_mem;
    bit st;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    st     = (op == OP_STORE);
    for (int i = 0; i < fw; i++)
      step(rbit(), 1'b0, 4'($urandom), V(1,0,0,0,0,0,0,1,0), "fetch_wait");
    step(rbit(), 1'b1, 4'($urandom), V(1,0,1,0,0,0,0,1,0), "fetch_ack");
    step(run_end ? rbit() : 1'b0, rbit(), op, V(0,0,0,0,0,0,0,1,0), "decode");
    if (!is_mem) begin
      step(run_end, rbit(), op, V(0,0,0,1,0,1,1,1,0), "exec_done");
    end else begin
      step(rbit(), rbit(), op, V(0,0,0,1,0,0,0,1,0), "exec_mem");
      for (int i = 0; i < mw; i++)
        step(rbit(), 1'b0, op, V(1,st,0,0,0,0,0,1,0), "mem_wait");
      step(run_end, 1'b1, op, V(1,st,0,0,!st,1,1,1,0), "mem_ack");
    end
  endtask

  // Sit in IDLE for n cycles with run low, then raise run to start fetching.
  task automatic idle_then_go(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, rbit(), 4'($urandom), V(0,0,0,0,0,0,0,0,0), "idle");
    step(1'b1, rbit(), 4'($urandom), V(0,0,0,0,0,0,0,0,0), "idle_go");
  endtask

  initial begin
    logic run_end;
    i_reset   = 1'b1;
    i_run     = 1'b0;
    i_opcode  = 4'd0;
    i_mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_eq("reset_state", 32'(outs()), 32'(V(0,0,0,0,0,0,0,0,0)));
    i_reset = 1'b0;

    idle_then_go(1);
    do_instr(OP_ADD, 0, 0, 1'b1);
    do_instr(OP_LOAD, 0, 2, 1'b1);
    do_instr(OP_STORE, 0, 2, 1'b1);
    do_instr(OP_NOP, 1, 0, 1'b0);
    idle_then_go(3);
    do_instr(OP_UNDEF, 0, 0, 1'b1);

    // STORE interrupted by reset while waiting in MEM
    step(1'b1, 1'b1, 4'($urandom), V(1,0,1,0,0,0,0,1,0), "st_fetch");
    step(1'b1, 1'b0, OP_STORE, V(0,0,0,0,0,0,0,1,0), "st_decode");
    step(1'b1, 1'b0, OP_STORE, V(0,0,0,1,0,0,0,1,0), "st_exec");
    step(1'b1, 1'b0, OP_STORE, V(1,1,0,0,0,0,0,1,0), "st_mem");
    @(negedge clk);
    i_reset = 1'b1;
    #1 check_eq("rst_mid_mem", 32'(outs()), 32'(V(0,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    #1 check_eq("rst_held", 32'(outs()), 32'(V(0,0,0,0,0,0,0,0,0)));
    i_reset = 1'b0;
    i_run   = 1'b1;
    do_instr(OP_ADD, 1, 0, 1'b1);

    for (int k = 0; k < 150; k++) begin
      run_end = (k == 149) ? 1'b0 : ($urandom_range(0, 3) != 0);
      do_instr(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), run_end);
      if (!run_end) idle_then_go($urandom_range(0, 3));
    end

`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++)
      step(1'b1, 1'b0, 4'($urandom), V(1,0,0,0,0,0,0,1,0), "to_fetch_wait");
    for (int i = 0; i < 6; i++)
      step(rbit(), rbit(), 4'($urandom), V(0,0,0,0,0,0,0,1,1), "fault_sticky");
`else
    for (int i = 0; i < 20; i++)
      step(rbit(), 1'b0, 4'($urandom), V(1,0,0,0,0,0,0,1,0), "long_wait");
`endif
    @(negedge clk);
    i_reset = 1'b1;
    #1 check_eq("rst_clear", 32'(outs()), 32'(V(0,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    i_reset = 1'b0;
    i_run   = 1'b0;
    step(1'b0, 1'b0, 4'd0, V(0,0,0,0,0,0,0,0,0), "post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
